// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
// Segment bit order is g..a from bit 6 down to bit 0, and segments are active-low.
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/swi_sync_debounce.sv
// Synchronizes an asynchronous board switch and optionally debounces it.
// The filtered level changes only after the synced input differs for DEBOUNCE_CYCLES cycles.
module swi_sync_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   swi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign swi_sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filter stage, so the select path is exactly SYNC_STAGES + 1 edges long.
    assign out = swi_sync;
  end else begin : g_filter
    localparam int unsigned CntW = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ?
                                   $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    logic            sel_d, sel_q;
    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
      sel_d = sel_q;
      cnt_d = '0;
      if (swi_sync != sel_q) begin
        if (cnt_q == CntLast) begin
          sel_d = swi_sync;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sel_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        sel_q <= sel_d;
        cnt_q <= cnt_d;
      end
    end

    assign out = sel_q;
  end

endmodule

// File: rtl/seg_error_mux.sv
// Registered 2:1 selector driving the segment pins with either the decoded digit
// or the error pattern, chosen by a synchronized and optionally debounced switch.
module seg_error_mux
  import seg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter seg_t        RESET_PATTERN   = SEG_BLANK
) (
  input  logic clk,
  input  logic rst,
  input  seg_t siete_seg,
  input  seg_t error,
  input  logic swi,
  output seg_t salida_mux
);

  logic sel_f;
  seg_t salida_d, salida_q;

  swi_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_swi_sync_debounce (
    .clk(clk),
    .rst(rst),
    .in (swi),
    .out(sel_f)
  );

  always_comb begin
    salida_d = sel_f ? error : siete_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      salida_q <= RESET_PATTERN;
    end else begin
      salida_q <= salida_d;
    end
  end

  assign salida_mux = salida_q;

endmodule

// File: tb/tb_seg_error_mux.sv
// Bench for seg_error_mux: a default instance and a DEBOUNCE_CYCLES=4 instance share
// stimulus and are checked against a cycle-history reference model.
module tb_seg_error_mux;
  import seg_pkg::*;

  localparam int unsigned S  = 2;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_t siete_seg = '0;
  seg_t error = '0;
  logic swi = 1'bx;
  seg_t out_def, out_db;

  int total = 0;
  int bad   = 0;

  seg_error_mux u_def (
    .clk       (clk),
    .rst       (rst),
    .siete_seg (siete_seg),
    .error     (error),
    .swi       (swi),
    .salida_mux(out_def)
  );

  seg_error_mux #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DB)
  ) u_db (
    .clk       (clk),
    .rst       (rst),
    .siete_seg (siete_seg),
    .error     (error),
    .swi       (swi),
    .salida_mux(out_db)
  );

  always #5 clk = ~clk;

  // Reference model: the switch value seen by the selector is the one sampled S edges ago;
  // the debounced level flips once that value has disagreed with it for DB edges in a row.
  bit   hist[$];
  bit   filt;
  int   run;
  seg_t exp_def = SEG_BLANK;
  seg_t exp_db  = SEG_BLANK;

  always @(posedge clk) begin
    bit s;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(1'b0);
      filt    = 1'b0;
      run     = 0;
      exp_def = SEG_BLANK;
      exp_db  = SEG_BLANK;
    end else begin
      s       = hist[0];
      exp_def = s ? error : siete_seg;
      exp_db  = filt ? error : siete_seg;
      if (s != filt) begin
        run++;
        if (run == DB) begin
          filt = s;
          run  = 0;
        end
      end else begin
        run = 0;
      end
      void'(hist.pop_front());
      hist.push_back(swi === 1'b1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    siete_seg = 7'b0000000;
    error     = 7'b0000000;
    rst       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (out_def !== 7'b1111111) begin
        bad++;
        $display("FAIL reset_def cyc%0d: got %b want %b", i, out_def, 7'b1111111);
      end
      total++;
      if (out_db !== 7'b1111111) begin
        bad++;
        $display("FAIL reset_db cyc%0d: got %b want %b", i, out_db, 7'b1111111);
      end
    end
    swi = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if (out_def !== 7'b0000000) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", out_def, 7'b0000000);
    end
  endtask

  task automatic test_normal();
    swi       = 1'b0;
    siete_seg = 7'b1010101;
    error     = 7'b1100110;
    step();
    total++;
    if (out_def !== 7'b1010101) begin
      bad++;
      $display("FAIL normal_select: got %b want %b", out_def, 7'b1010101);
    end
  endtask

  task automatic test_error_select();
    swi = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      total++;
      if (out_def !== ((e >= 3) ? 7'b1100110 : 7'b1010101)) begin
        bad++;
        $display("FAIL error_select edge%0d: got %b want %b", e, out_def,
                 (e >= 3) ? 7'b1100110 : 7'b1010101);
      end
    end
  endtask

  task automatic test_swap();
    siete_seg = 7'b1111111;
    error     = 7'b0000000;
    swi       = 1'b0;
    step(10);
    total++;
    if (out_def !== 7'b1111111 || out_db !== 7'b1111111) begin
      bad++;
      $display("FAIL swap_seg: got def=%b db=%b want %b", out_def, out_db, 7'b1111111);
    end
    swi = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if (out_def !== ((e == 3) ? 7'b0000000 : 7'b1111111)) begin
        bad++;
        $display("FAIL swap_err edge%0d: got %b want %b", e, out_def,
                 (e == 3) ? 7'b0000000 : 7'b1111111);
      end
    end
  endtask

  task automatic test_debounce_glitch();
    siete_seg = 7'b0001111;
    error     = 7'b1110000;
    swi       = 1'b0;
    step(10);
    swi = 1'b1;
    step(3);
    swi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (out_db !== 7'b0001111 || out_db !== exp_db) begin
        bad++;
        $display("FAIL glitch cyc%0d: got %b want %b", i, out_db, 7'b0001111);
      end
    end
  endtask

  task automatic test_debounce_step();
    swi = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      total++;
      if (out_db !== ((e >= 7) ? 7'b1110000 : 7'b0001111)) begin
        bad++;
        $display("FAIL db_step edge%0d: got %b want %b", e, out_db,
                 (e >= 7) ? 7'b1110000 : 7'b0001111);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    swi = 1'b0;
    step(10);
    swi = 1'b1;
    step(4);
    rst = 1'b1;
    step();
    total++;
    if (out_db !== 7'b1111111 || out_def !== 7'b1111111) begin
      bad++;
      $display("FAIL mid_reset: got def=%b db=%b want %b", out_def, out_db, 7'b1111111);
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step();
      total++;
      if (out_db !== ((e >= 7) ? 7'b1110000 : 7'b0001111)) begin
        bad++;
        $display("FAIL mid_reset_db edge%0d: got %b want %b", e, out_db,
                 (e >= 7) ? 7'b1110000 : 7'b0001111);
      end
      total++;
      if (out_def !== exp_def) begin
        bad++;
        $display("FAIL mid_reset_def edge%0d: got %b want %b", e, out_def, exp_def);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 400; i++) begin
      siete_seg = seg_t'($urandom);
      error     = seg_t'($urandom);
      if (hold == 0) begin
        swi  = ~swi;
        hold = $urandom_range(1, 8);
      end
      hold--;
      rst = ($urandom_range(0, 99) == 0);
      step();
      total++;
      if (out_def !== exp_def) begin
        bad++;
        $display("FAIL rand_def i=%0d: got %b want %b", i, out_def, exp_def);
      end
      total++;
      if (out_db !== exp_db) begin
        bad++;
        $display("FAIL rand_db i=%0d: got %b want %b", i, out_db, exp_db);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal();
    test_error_select();
    test_swap();
    test_debounce_glitch();
    test_debounce_step();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
